// File: rtl/ws_pe_dbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ws_pe_dbuf                                                       |
// | Brief   : signed weight-stationary MAC PE with ping-pong weight banks.     |
// |           Define WS_PE_SAT_EN to clamp psum_out on overflow.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ws_pe_dbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_load,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_swap,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] input_in,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] input_out,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  active_bank,
  output logic                  w_pending,
  output logic                  swap_err,
  output logic                  ovf
);

  localparam int c_prod_w = 2 * DATA_WIDTH;
  localparam int c_ext_w  = ACC_WIDTH + 1 - c_prod_w;
  localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] bank0_q, bank0_d;
  logic [DATA_WIDTH-1:0] bank1_q, bank1_d;
  logic                  active_bank_q, active_bank_d;
  logic                  w_pending_q, w_pending_d;
  logic                  swap_err_q, swap_err_d;
  logic                  valid_out_q, valid_out_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] input_out_q, input_out_d;
  logic [ACC_WIDTH-1:0]  psum_out_q, psum_out_d;

  logic [DATA_WIDTH-1:0] w_weight;
  logic [c_prod_w-1:0]   w_in_ext;
  logic [c_prod_w-1:0]   w_wt_ext;
  logic [c_prod_w-1:0]   w_prod;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_sum_ovf;
  logic [ACC_WIDTH-1:0]  w_result;
  logic                  w_swap_ok;

  // Datapath: low 2*DATA_WIDTH bits of the product of sign-extended operands
  // equal the signed product; one guard bit on the sum exposes overflow.
  always_comb begin
    w_weight  = active_bank_q ? bank1_q : bank0_q;
    w_in_ext  = {{DATA_WIDTH{input_in[DATA_WIDTH-1]}}, input_in};
    w_wt_ext  = {{DATA_WIDTH{w_weight[DATA_WIDTH-1]}}, w_weight};
    w_prod    = w_in_ext * w_wt_ext;
    w_sum     = {psum_in[ACC_WIDTH-1], psum_in}
              + {{c_ext_w{w_prod[c_prod_w-1]}}, w_prod};
    w_sum_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    w_result  = w_sum[ACC_WIDTH-1:0];
`ifdef WS_PE_SAT_EN
    if (w_sum_ovf) begin
      w_result = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
    end
`else
`endif
  end

  always_comb begin
    bank0_d       = bank0_q;
    bank1_d       = bank1_q;
    active_bank_d = active_bank_q;
    w_pending_d   = w_pending_q;
    valid_out_d   = valid_in;
    ovf_d         = ovf_q;
    input_out_d   = input_out_q;
    psum_out_d    = psum_out_q;
    w_swap_ok     = w_swap & w_pending_q;
    swap_err_d    = w_swap & ~w_pending_q;

    // The load always targets the pre-swap shadow bank.
    if (w_load) begin
      if (active_bank_q) bank0_d = w_data;
      else               bank1_d = w_data;
    end

    if (w_swap_ok) begin
      active_bank_d = ~active_bank_q;
      w_pending_d   = 1'b0;
    end else if (w_load) begin
      w_pending_d   = 1'b1;
    end

    if (valid_in) begin
      psum_out_d  = w_result;
      input_out_d = input_in;
      ovf_d       = w_sum_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank0_q       <= '0;
      bank1_q       <= '0;
      active_bank_q <= 1'b0;
      w_pending_q   <= 1'b0;
      swap_err_q    <= 1'b0;
      valid_out_q   <= 1'b0;
      ovf_q         <= 1'b0;
      input_out_q   <= '0;
      psum_out_q    <= '0;
    end else begin
      bank0_q       <= bank0_d;
      bank1_q       <= bank1_d;
      active_bank_q <= active_bank_d;
      w_pending_q   <= w_pending_d;
      swap_err_q    <= swap_err_d;
      valid_out_q   <= valid_out_d;
      ovf_q         <= ovf_d;
      input_out_q   <= input_out_d;
      psum_out_q    <= psum_out_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign input_out   = input_out_q;
  assign psum_out    = psum_out_q;
  assign active_bank = active_bank_q;
  assign w_pending   = w_pending_q;
  assign swap_err    = swap_err_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire
